sync_ctrl_mc: RTL and testbench
===============================

# sync_ctrl_mc

Parametrised frame-synchronisation controller for the 50 MHz baseband domain. It arms on a coarse-sync detection and commits the coarse position at the next slot interrupt. It then tracks fine-sync updates, rejecting fine positions that jump by more than a programmable step and declaring loss after repeated rejects. Its one-hot send-rate enable steps down through `N_RATE` transmit rates as fine lock is confirmed, and feeds the transmit framers.

## Interface
- `POS_W`, 32: width of coarse/fine position words.
- `N_RATE`, 2 (min 2): number of send rates. Bit 0 is the acquisition rate (40k); bit `N_RATE-1` is the slowest tracking rate (10k).
- `SLOT_TO`, 50000 (min 2): cycles to wait in ARMED for `slot_interrupt`.
- `FINE_MAX_STEP`, 64: largest accepted |new fine − current fine|.
- `REJ_LIMIT`, 4 (min 1): consecutive fine rejects that force loss.
- `clk_50m`, in, 1: clock.
- `cfg_rst`, in, 1: reset, asynchronous, active-high.
- `lose`, in, 1: external loss-of-sync level.
- `coarse_syn_en`, in, 1: coarse detection pulse.
- `fine_syn_en`, in, 1: fine update pulse.
- `slot_interrupt`, in, 1: slot boundary pulse.
- `coarse_syn_pos`, in, `POS_W`: coarse position. Sampled in ARMED on `slot_interrupt`.
- `fine_syn_pos`, in, `POS_W`: fine position. Sampled on the cycle `fine_syn_en` is high.
- `data_send_end`, in, 1: end-of-burst pulse. Returns the rate to acquisition.
- `coarse_pos`, out, `POS_W`: committed coarse position.
- `fine_pos`, out, `POS_W`: committed fine position.
- `send_en`, out, `N_RATE`: one-hot rate enable, or all zero.
- `locked`, out, 1: high in TRACK/FINE and during re-arm from TRACK.
- `slot_timeout`, out, 1: one-cycle pulse on ARMED timeout.
- `fine_reject`, out, 1: one-cycle pulse per rejected fine update.
- `syn_state`, out, 2: current state encoding.

## Operation
- States and encodings: SEARCH=0, ARMED=1, TRACK=2, FINE=3.
- **Reset:** state SEARCH. All outputs and internal registers are zero: positions, `send_en`, `locked`, pulses, timer, `rej_cnt`, `rate_idx`, `fine_valid`.
- **`lose` (any state, highest priority):** next state SEARCH; `send_en`=0, `locked`=0, `rej_cnt`=0. `coarse_pos` and `fine_pos` are held.
- **SEARCH:**
  - `coarse_syn_en` → ARMED, timer cleared.
  - `fine_syn_en` and `data_send_end` are ignored.
- **ARMED:**
  - Timer increments each cycle.
  - `slot_interrupt` → commit and go to TRACK:
    - `coarse_pos` ← `coarse_syn_pos`;
    - `rate_idx` ← 0 and `send_en` ← 1 (bit 0);
    - `locked` ← 1, `fine_valid` ← 0, `rej_cnt` ← 0.
  - Timer = `SLOT_TO-1` with no interrupt → `slot_timeout` pulse, then SEARCH (outputs as on loss). If arming came from TRACK, `locked` and `send_en` clear at that point.
  - `slot_interrupt` on the timeout cycle wins; no pulse is generated.
- **TRACK:**
  - Priority is `coarse_syn_en` > `fine_syn_en` > `data_send_end`.
  - `coarse_syn_en` → ARMED (re-acquire). `send_en` and `locked` are held.
  - `fine_syn_en` → FINE, with `fine_syn_pos` captured into `fine_cap`.
  - `data_send_end` → `rate_idx` ← 0, `send_en` ← bit 0.
- **FINE (one cycle, always returns to TRACK unless loss):**
  - diff = |`fine_cap` − `fine_pos`|, computed in `POS_W+1` bits unsigned.
  - Accept when `fine_valid`=0, or `fine_cap`=0 (clear request), or diff ≤ `FINE_MAX_STEP`. On accept:
    - `fine_pos` ← `fine_cap`, `fine_valid` ← 1, `rej_cnt` ← 0;
    - `rate_idx` ← min(`rate_idx`+1, `N_RATE`-1), and `send_en` tracks it.
  - Otherwise reject: `fine_reject` pulse and `rej_cnt`+1.
  - If `rej_cnt`+1 = `REJ_LIMIT`, go to SEARCH with loss outputs instead of TRACK.
  - Events arriving during FINE are dropped.
- `send_en` is always either exactly one-hot at `rate_idx` or all zero.

## Timing
- All outputs are registered. No combinational input-to-output paths.
- Coarse commit:
  - `slot_interrupt` high in cycle t (in ARMED) → `coarse_pos`, `send_en`, `locked` valid from cycle t+1.
  - Minimum `coarse_syn_en`→commit latency is 2 cycles.
- Fine update: `fine_syn_en` in cycle t → `fine_pos`/`send_en` update or `fine_reject` visible in cycle t+2.
- A timeout pulse asserts in the cycle after the `SLOT_TO`-th ARMED cycle.
- `cfg_rst` mid-operation clears everything immediately (asynchronous). Operation resumes on the first clock edge after deassertion.

## Test plan
- **Coarse commit:** reset, `coarse_syn_en`, then `slot_interrupt` 10 cycles later with `coarse_syn_pos`=0x1234 → `coarse_pos`=0x1234, `send_en`=2'b01, `locked`=1, `syn_state`=2.
- **Slot timeout:** `SLOT_TO`=16, `coarse_syn_en` and no slot → `slot_timeout` pulses exactly once, 16 cycles after ARMED entry; state returns to 0.
- **Fine accept/reject:** after lock, fine 0x100 (accept; `send_en`=2'b10), then 0x130 (accept), then 0x200 (diff 0xD0 > 64) → one `fine_reject` pulse and `fine_pos` stays 0x130.
- **Reject limit:** 4 consecutive out-of-step fine updates → loss on the 4th: `send_en`=0, `locked`=0, state 0, positions held.
- **Priority and rate reset:**
  - `lose` together with `fine_syn_en` in TRACK → SEARCH, no fine update.
  - `data_send_end` at `rate_idx`=1 → `send_en`=2'b01.
- **Mid-operation reset:** `cfg_rst` pulsed while in FINE → all outputs are zero on the next sample.

Source files
------------

// File: rtl/sync_ctrl_mc.sv
// rtl/sync_ctrl_mc.sv - frame-synchronisation controller: coarse arm/commit, fine tracking, send-rate enable
module sync_ctrl_mc #(
    parameter int POS_W         = 32,
    parameter int N_RATE        = 2,
    parameter int SLOT_TO       = 50000,
    parameter int FINE_MAX_STEP = 64,
    parameter int REJ_LIMIT     = 4
) (
    input  logic              clk_50m,
    input  logic              cfg_rst,
    input  logic              lose,
    input  logic              coarse_syn_en,
    input  logic              fine_syn_en,
    input  logic              slot_interrupt,
    input  logic [POS_W-1:0]  coarse_syn_pos,
    input  logic [POS_W-1:0]  fine_syn_pos,
    input  logic              data_send_end,
    output logic [POS_W-1:0]  coarse_pos,
    output logic [POS_W-1:0]  fine_pos,
    output logic [N_RATE-1:0] send_en,
    output logic              locked,
    output logic              slot_timeout,
    output logic              fine_reject,
    output logic [1:0]        syn_state
);

    localparam int RW = (N_RATE > 1) ? $clog2(N_RATE) : 1;
    localparam int TW = (SLOT_TO > 1) ? $clog2(SLOT_TO) : 1;
    localparam int CW = $clog2(REJ_LIMIT + 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;
    localparam logic [1:0] ST_FINE   = 2'd3;

    localparam logic [TW-1:0]    TIMER_LAST = TW'(SLOT_TO - 1);
    localparam logic [RW-1:0]    RATE_LAST  = RW'(N_RATE - 1);
    localparam logic [CW-1:0]    REJ_MAX    = CW'(REJ_LIMIT);
    localparam logic [POS_W:0]   MAX_STEP   = (POS_W + 1)'(FINE_MAX_STEP);

    // Registered state
    logic [1:0]        r_state;
    logic [TW-1:0]     r_timer;
    logic [CW-1:0]     r_rej_cnt;
    logic [RW-1:0]     r_rate_idx;
    logic              r_fine_valid;
    logic [POS_W-1:0]  r_fine_cap;
    logic [POS_W-1:0]  r_coarse_pos;
    logic [POS_W-1:0]  r_fine_pos;
    logic [N_RATE-1:0] r_send_en;
    logic              r_locked;
    logic              r_slot_timeout;
    logic              r_fine_reject;

    // Next-state values
    logic [1:0]        w_state;
    logic [TW-1:0]     w_timer;
    logic [CW-1:0]     w_rej_cnt;
    logic [RW-1:0]     w_rate_idx;
    logic              w_fine_valid;
    logic [POS_W-1:0]  w_fine_cap;
    logic [POS_W-1:0]  w_coarse_pos;
    logic [POS_W-1:0]  w_fine_pos;
    logic [N_RATE-1:0] w_send_en;
    logic              w_locked;
    logic              w_slot_timeout;
    logic              w_fine_reject;

    // Fine acceptance helpers
    logic [POS_W:0]    w_cap_ext;
    logic [POS_W:0]    w_pos_ext;
    logic [POS_W:0]    w_diff;
    logic              w_accept;
    logic [CW-1:0]     w_rej_next;
    logic [RW-1:0]     w_rate_up;

    function automatic logic [N_RATE-1:0] rate_onehot(input logic [RW-1:0] idx);
        logic [N_RATE-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Distance between the captured fine position and the committed one, and the accept decision
    always_comb begin
        w_cap_ext  = {1'b0, r_fine_cap};
        w_pos_ext  = {1'b0, r_fine_pos};
        w_diff     = (w_cap_ext >= w_pos_ext) ? (w_cap_ext - w_pos_ext) : (w_pos_ext - w_cap_ext);
        w_accept   = !r_fine_valid || (r_fine_cap == '0) || (w_diff <= MAX_STEP);
        w_rej_next = r_rej_cnt + CW'(1);
        w_rate_up  = (r_rate_idx == RATE_LAST) ? RATE_LAST : (r_rate_idx + RW'(1));
    end

    // Next-state and output decisions; loss dominates every state
    always_comb begin
        w_state        = r_state;
        w_timer        = r_timer;
        w_rej_cnt      = r_rej_cnt;
        w_rate_idx     = r_rate_idx;
        w_fine_valid   = r_fine_valid;
        w_fine_cap     = r_fine_cap;
        w_coarse_pos   = r_coarse_pos;
        w_fine_pos     = r_fine_pos;
        w_send_en      = r_send_en;
        w_locked       = r_locked;
        w_slot_timeout = 1'b0;
        w_fine_reject  = 1'b0;

        if (lose) begin
            w_state    = ST_SEARCH;
            w_send_en  = '0;
            w_locked   = 1'b0;
            w_rej_cnt  = '0;
            w_rate_idx = '0;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    if (coarse_syn_en) begin
                        w_state = ST_ARMED;
                        w_timer = '0;
                    end
                end
                ST_ARMED: begin
                    w_timer = r_timer + TW'(1);
                    if (slot_interrupt) begin
                        // Commit the coarse position and start at the acquisition rate
                        w_state      = ST_TRACK;
                        w_coarse_pos = coarse_syn_pos;
                        w_rate_idx   = '0;
                        w_send_en    = rate_onehot('0);
                        w_locked     = 1'b1;
                        w_fine_valid = 1'b0;
                        w_rej_cnt    = '0;
                    end else if (r_timer == TIMER_LAST) begin
                        w_slot_timeout = 1'b1;
                        w_state        = ST_SEARCH;
                        w_send_en      = '0;
                        w_locked       = 1'b0;
                        w_rej_cnt      = '0;
                        w_rate_idx     = '0;
                    end
                end
                ST_TRACK: begin
                    if (coarse_syn_en) begin
                        // Re-acquire while keeping the current rate and lock visible
                        w_state = ST_ARMED;
                        w_timer = '0;
                    end else if (fine_syn_en) begin
                        w_state    = ST_FINE;
                        w_fine_cap = fine_syn_pos;
                    end else if (data_send_end) begin
                        w_rate_idx = '0;
                        w_send_en  = rate_onehot('0);
                    end
                end
                ST_FINE: begin
                    w_state = ST_TRACK;
                    if (w_accept) begin
                        w_fine_pos   = r_fine_cap;
                        w_fine_valid = 1'b1;
                        w_rej_cnt    = '0;
                        w_rate_idx   = w_rate_up;
                        w_send_en    = rate_onehot(w_rate_up);
                    end else begin
                        w_fine_reject = 1'b1;
                        if (w_rej_next == REJ_MAX) begin
                            w_state    = ST_SEARCH;
                            w_send_en  = '0;
                            w_locked   = 1'b0;
                            w_rej_cnt  = '0;
                            w_rate_idx = '0;
                        end else begin
                            w_rej_cnt = w_rej_next;
                        end
                    end
                end
                default: begin
                    w_state = ST_SEARCH;
                end
            endcase
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_50m or posedge cfg_rst) begin
        if (cfg_rst) begin
            r_state        <= ST_SEARCH;
            r_timer        <= '0;
            r_rej_cnt      <= '0;
            r_rate_idx     <= '0;
            r_fine_valid   <= 1'b0;
            r_fine_cap     <= '0;
            r_coarse_pos   <= '0;
            r_fine_pos     <= '0;
            r_send_en      <= '0;
            r_locked       <= 1'b0;
            r_slot_timeout <= 1'b0;
            r_fine_reject  <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_timer        <= w_timer;
            r_rej_cnt      <= w_rej_cnt;
            r_rate_idx     <= w_rate_idx;
            r_fine_valid   <= w_fine_valid;
            r_fine_cap     <= w_fine_cap;
            r_coarse_pos   <= w_coarse_pos;
            r_fine_pos     <= w_fine_pos;
            r_send_en      <= w_send_en;
            r_locked       <= w_locked;
            r_slot_timeout <= w_slot_timeout;
            r_fine_reject  <= w_fine_reject;
        end
    end

    assign coarse_pos   = r_coarse_pos;
    assign fine_pos     = r_fine_pos;
    assign send_en      = r_send_en;
    assign locked       = r_locked;
    assign slot_timeout = r_slot_timeout;
    assign fine_reject  = r_fine_reject;
    assign syn_state    = r_state;

endmodule

// File: tb/tb_sync_ctrl_mc.sv
// tb/tb_sync_ctrl_mc.sv - self-checking bench for sync_ctrl_mc with directed and randomized steps
module tb_sync_ctrl_mc;

    localparam int POS_W     = 32;
    localparam int N_RATE    = 2;
    localparam int SLOT_TO   = 16;
    localparam int STEP      = 64;
    localparam int REJ_LIMIT = 4;

    logic              clk_50m = 1'b0;
    logic              cfg_rst = 1'b1;
    logic              lose = 1'b0;
    logic              coarse_syn_en = 1'b0;
    logic              fine_syn_en = 1'b0;
    logic              slot_interrupt = 1'b0;
    logic [POS_W-1:0]  coarse_syn_pos = '0;
    logic [POS_W-1:0]  fine_syn_pos = '0;
    logic              data_send_end = 1'b0;
    logic [POS_W-1:0]  coarse_pos;
    logic [POS_W-1:0]  fine_pos;
    logic [N_RATE-1:0] send_en;
    logic              locked;
    logic              slot_timeout;
    logic              fine_reject;
    logic [1:0]        syn_state;

    sync_ctrl_mc #(
        .POS_W(POS_W), .N_RATE(N_RATE), .SLOT_TO(SLOT_TO),
        .FINE_MAX_STEP(STEP), .REJ_LIMIT(REJ_LIMIT)
    ) dut (
        .clk_50m(clk_50m), .cfg_rst(cfg_rst), .lose(lose),
        .coarse_syn_en(coarse_syn_en), .fine_syn_en(fine_syn_en),
        .slot_interrupt(slot_interrupt), .coarse_syn_pos(coarse_syn_pos),
        .fine_syn_pos(fine_syn_pos), .data_send_end(data_send_end),
        .coarse_pos(coarse_pos), .fine_pos(fine_pos), .send_en(send_en),
        .locked(locked), .slot_timeout(slot_timeout), .fine_reject(fine_reject),
        .syn_state(syn_state)
    );

    always #10 clk_50m = ~clk_50m;

    int tests = 0;
    int failed = 0;

    // Reference model: spec-level view of the controller
    int          m_state;
    int          m_armed_cycles;
    int          m_rej;
    int          m_rate;
    bit          m_active;
    bit          m_locked;
    bit          m_fine_valid;
    bit          m_to_pulse;
    bit          m_rej_pulse;
    logic [31:0] m_coarse;
    logic [31:0] m_fine;
    logic [31:0] m_cap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_armed_cycles = 0; m_rej = 0; m_rate = 0;
        m_active = 0; m_locked = 0; m_fine_valid = 0;
        m_to_pulse = 0; m_rej_pulse = 0;
        m_coarse = '0; m_fine = '0; m_cap = '0;
    endtask

    task automatic model_lost();
        m_state = 0; m_active = 0; m_locked = 0; m_rej = 0;
    endtask

    task automatic model_step();
        longint d;
        m_to_pulse  = 0;
        m_rej_pulse = 0;
        if (lose) begin
            model_lost();
        end else if (m_state == 0) begin
            if (coarse_syn_en) begin m_state = 1; m_armed_cycles = 0; end
        end else if (m_state == 1) begin
            m_armed_cycles++;
            if (slot_interrupt) begin
                m_coarse = coarse_syn_pos; m_rate = 0; m_active = 1; m_locked = 1;
                m_fine_valid = 0; m_rej = 0; m_state = 2;
            end else if (m_armed_cycles == SLOT_TO) begin
                m_to_pulse = 1;
                model_lost();
            end
        end else if (m_state == 2) begin
            if (coarse_syn_en) begin m_state = 1; m_armed_cycles = 0; end
            else if (fine_syn_en) begin m_cap = fine_syn_pos; m_state = 3; end
            else if (data_send_end) m_rate = 0;
        end else begin
            d = (m_cap > m_fine) ? longint'(m_cap) - longint'(m_fine) : longint'(m_fine) - longint'(m_cap);
            m_state = 2;
            if (!m_fine_valid || m_cap == 0 || d <= STEP) begin
                m_fine = m_cap; m_fine_valid = 1; m_rej = 0;
                m_rate = (m_rate + 1 > N_RATE - 1) ? N_RATE - 1 : m_rate + 1;
            end else begin
                m_rej_pulse = 1;
                m_rej++;
                if (m_rej == REJ_LIMIT) model_lost();
            end
        end
    endtask

    task automatic check_model();
        logic [N_RATE-1:0] exp_send;
        exp_send = m_active ? N_RATE'(1 << m_rate) : '0;
        check("state", syn_state, 64'(m_state));
        check("coarse_pos", coarse_pos, m_coarse);
        check("fine_pos", fine_pos, m_fine);
        check("send_en", send_en, exp_send);
        check("locked", locked, m_locked);
        check("slot_timeout", slot_timeout, m_to_pulse);
        check("fine_reject", fine_reject, m_rej_pulse);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_50m);
        #1;
        check_model();
        lose = 0; coarse_syn_en = 0; fine_syn_en = 0; slot_interrupt = 0; data_send_end = 0;
    endtask

    task automatic fine_upd(input logic [31:0] pos);
        fine_syn_en = 1; fine_syn_pos = pos;
        tick();
        tick();
    endtask

    task automatic relock(input logic [31:0] pos);
        coarse_syn_en = 1;
        tick();
        slot_interrupt = 1; coarse_syn_pos = pos;
        tick();
    endtask

    initial begin
        int to_cnt;
        int to_at;
        model_reset();
        repeat (3) @(posedge clk_50m);
        #1;
        check_model();
        check("rst_send_en", send_en, 0);
        check("rst_locked", locked, 0);
        cfg_rst = 0;

        // Coarse commit ten cycles after detection
        coarse_syn_en = 1;
        tick();
        repeat (9) tick();
        slot_interrupt = 1; coarse_syn_pos = 32'h1234;
        tick();
        check("commit_coarse", coarse_pos, 32'h1234);
        check("commit_send", send_en, 2'b01);
        check("commit_locked", locked, 1);
        check("commit_state", syn_state, 2);

        // Fine accept / accept / reject; fine_pos only moves two cycles after the pulse
        fine_syn_en = 1; fine_syn_pos = 32'h100;
        tick();
        check("fine_t1_pos", fine_pos, 0);
        tick();
        check("fine1_pos", fine_pos, 32'h100);
        check("fine1_send", send_en, 2'b10);
        fine_upd(32'h130);
        check("fine2_pos", fine_pos, 32'h130);
        fine_upd(32'h200);
        check("fine3_reject", fine_reject, 1);
        check("fine3_pos", fine_pos, 32'h130);

        // Reject limit: clear count with an accept, then four far updates
        fine_upd(32'h140);
        for (int i = 0; i < 3; i++) begin
            fine_upd(32'h400 + 32'(i) * 32'h100);
            check("rej_still_locked", locked, 1);
        end
        fine_upd(32'h800);
        check("rej4_state", syn_state, 0);
        check("rej4_send", send_en, 0);
        check("rej4_locked", locked, 0);
        check("rej4_coarse", coarse_pos, 32'h1234);
        check("rej4_fine", fine_pos, 32'h140);

        // Slot timeout from SEARCH
        coarse_syn_en = 1;
        tick();
        to_cnt = 0; to_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (slot_timeout) begin to_cnt++; to_at = i; end
        end
        check("to_count", to_cnt, 1);
        check("to_cycle", to_at, 16);
        check("to_state", syn_state, 0);

        // lose beats fine_syn_en in TRACK
        relock(32'h55);
        check("relock_state", syn_state, 2);
        lose = 1; fine_syn_en = 1; fine_syn_pos = 32'h999;
        tick();
        check("lose_state", syn_state, 0);
        tick();
        check("lose_fine_held", fine_pos, 32'h140);
        check("lose_state2", syn_state, 0);

        // data_send_end returns to acquisition rate
        relock(32'h66);
        fine_upd(32'h150);
        check("dse_pre_send", send_en, 2'b10);
        data_send_end = 1;
        tick();
        check("dse_send", send_en, 2'b01);

        // Step boundary and clear request
        fine_upd(32'h190);
        check("step64_accept", fine_pos, 32'h190);
        fine_upd(32'h1D1);
        check("step65_reject", fine_reject, 1);
        fine_upd(32'h0);
        check("clear_accept", fine_pos, 0);

        // Asynchronous reset while in FINE
        fine_syn_en = 1; fine_syn_pos = 32'h180;
        tick();
        check("in_fine", syn_state, 3);
        cfg_rst = 1;
        #2;
        model_reset();
        check_model();
        check("midrst_coarse", coarse_pos, 0);
        #2;
        cfg_rst = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            lose           = ($urandom_range(0, 63) == 0);
            coarse_syn_en  = ($urandom_range(0, 15) == 0);
            slot_interrupt = ($urandom_range(0, 7) == 0);
            fine_syn_en    = ($urandom_range(0, 3) == 0);
            data_send_end  = ($urandom_range(0, 15) == 0);
            coarse_syn_pos = $urandom;
            case ($urandom_range(0, 3))
                0:       fine_syn_pos = '0;
                1:       fine_syn_pos = $urandom;
                default: fine_syn_pos = m_fine + 32'($urandom_range(0, 140)) - 32'd70;
            endcase
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
